reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/rf_pkg.sv | 12 +
 rtl/byte_en_register.sv | 37 +++
 rtl/reg_file.sv | 118 +++++++++++
 tb/tb_reg_file.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg
// Shared constants for the register file slice: default geometry,
// the width of the committed-write counter and its saturation value.
package rf_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

endpackage : rf_pkg

// File: rtl/byte_en_register.sv
// byte_en_register
// One WIDTH-bit storage register with an independent load enable per
// byte lane. The register clears asynchronously while rst is low.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   en   - per-byte load enables (bit i loads d[8i+7:8i])
//   d    - data to load
//   q    - current register contents
module byte_en_register
  import rf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH/8-1:0] en,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  // Each lane loads only when its own enable is set; the others keep
  // their value, which is what gives the file its partial-write behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (en[i]) begin
          q[8*i +: 8] <= d[8*i +: 8];
        end
      end
    end
  end

endmodule : byte_en_register

// File: rtl/reg_file.sv
// reg_file
// Multi-ported register file: one byte-strobed write port, two
// independent zero-latency read ports, optional hardwired zero register,
// optional write-to-read forwarding, and a saturating count of the
// writes that actually changed state.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset (clears registers and count)
//   we       - write enable
//   waddr    - write address
//   wdata    - write data
//   wstrb    - byte-lane write strobes
//   raddr_a  - read address, port A
//   raddr_b  - read address, port B
//   rdata_a  - read data, port A (combinational)
//   rdata_b  - read data, port B (combinational)
//   wr_count - saturating count of committed writes
module reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]      raddr_a,
  input  logic [AW-1:0]      raddr_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_b,
  output logic [COUNT_W-1:0] wr_count
);

  localparam int LANES = WIDTH / 8;

  logic             commit;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] fwd;

  // A write only counts when it can change something: at least one lane
  // strobed and not aimed at the hardwired zero register. The same signal
  // gates storage, forwarding and the counter so they can never disagree.
  assign commit = we && (|wstrb) && !(ZERO_REG && (waddr == '0));

  // Storage array. Entry 0 becomes a constant when it is hardwired to zero,
  // so no flops exist for it at all.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_flop
      logic [LANES-1:0] lane_en;

      assign lane_en = (commit && (waddr == AW'(g))) ? wstrb : '0;

      byte_en_register #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (lane_en),
        .d   (wdata),
        .q   (regs[g])
      );
    end
  end

  // Value the written register will hold after this edge: new bytes on the
  // strobed lanes, current contents elsewhere. Shared by both read ports.
  always_comb begin
    fwd = regs[waddr];
    for (int i = 0; i < LANES; i++) begin
      if (wstrb[i]) begin
        fwd[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Read ports. Address 0 needs no special case here: its entry is constant
  // zero and commit never fires for it when it is hardwired. Forwarding must
  // be masked during reset, otherwise a write held on the inputs would leak
  // out while the array itself is cleared.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (BYPASS && commit && (raddr_a == waddr)) begin
      rdata_a = fwd;
    end
    if (!rst) begin
      rdata_a = '0;
    end
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (BYPASS && commit && (raddr_b == waddr)) begin
      rdata_b = fwd;
    end
    if (!rst) begin
      rdata_b = '0;
    end
  end

  // Committed-write counter; sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (commit && (wr_count != COUNT_MAX)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb_reg_file
// Self-checking bench for reg_file. Two instances share all inputs: one
// with forwarding enabled (default parameters) and one with forwarding
// disabled. A behavioural model of the register contents and write count
// is checked against both instances on every falling clock edge, and
// directed scenarios add hand-computed literal expectations.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;

  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [15:0] wr_count;
  logic [31:0] nb_rdata_a;
  logic [31:0] nb_rdata_b;
  logic [15:0] nb_wr_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] mem [32];
  int          model_count;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .wr_count (wr_count)
  );

  reg_file #(
    .BYPASS (1'b0)
  ) dut_nb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (nb_rdata_a),
    .rdata_b  (nb_rdata_b),
    .wr_count (nb_wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model update: reset clears everything at once; a write with any strobe
  // set to a non-zero address replaces the strobed bytes and bumps the
  // count up to 65535.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      model_count = 0;
    end else if (we && (wstrb != 4'b0000) && (waddr != 5'd0)) begin
      for (int l = 0; l < 4; l++) begin
        if (wstrb[l]) mem[waddr][8*l +: 8] = wdata[8*l +: 8];
      end
      if (model_count < 65535) model_count = model_count + 1;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] addr, input bit fwd_on);
    logic [31:0] v;
    if (!rst || (addr == 5'd0)) return 32'h0;
    v = mem[addr];
    if (fwd_on && we && (wstrb != 4'b0000) && (addr == waddr)) begin
      for (int l = 0; l < 4; l++) begin
        if (wstrb[l]) v[8*l +: 8] = wdata[8*l +: 8];
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, so they are stable for
  // the whole following cycle.
  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    we      = w;
    waddr   = wa;
    wdata   = wd;
    wstrb   = ws;
    raddr_a = ra;
    raddr_b = rb;
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("model_rdata_a",    rdata_a,            model_read(raddr_a, 1'b1));
    checkOutput("model_rdata_b",    rdata_b,            model_read(raddr_b, 1'b1));
    checkOutput("model_nb_rdata_a", nb_rdata_a,         model_read(raddr_a, 1'b0));
    checkOutput("model_nb_rdata_b", nb_rdata_b,         model_read(raddr_b, 1'b0));
    checkOutput("model_wr_count",   {16'h0, wr_count},    32'(model_count));
    checkOutput("model_nb_wr_count",{16'h0, nb_wr_count}, 32'(model_count));
  end

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0; raddr_a = '0; raddr_b = '0;
    #3;
    checkOutput("reset_rdata_a", rdata_a, 32'h0);
    checkOutput("reset_wr_count", {16'h0, wr_count}, 32'h0);
    #9 rst = 1'b1;

    // Full write to reg 5, forwarded on one instance only
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111, 5'd5, 5'd5);
    #2;
    checkOutput("bypass_full_a", rdata_a, 32'hDEADBEEF);
    checkOutput("nobypass_full_a", nb_rdata_a, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd5, 5'd5);
    #2;
    checkOutput("read5_a", rdata_a, 32'hDEADBEEF);
    checkOutput("read5_b_equal", rdata_b, 32'hDEADBEEF);
    checkOutput("count_after_1", {16'h0, wr_count}, 32'd1);

    // Partial write keeps the unstrobed lanes
    applyStimulus(1'b1, 5'd5, 32'h11223344, 4'b0101, 5'd5, 5'd6);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd5, 5'd5);
    #2;
    checkOutput("partial_merge", rdata_a, 32'hDE22BE44);
    checkOutput("count_after_2", {16'h0, wr_count}, 32'd2);

    // Forwarding on reg 7: new value with bypass, old value without
    applyStimulus(1'b1, 5'd7, 32'h12345678, 4'b1111, 5'd7, 5'd5);
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 4'b1111, 5'd7, 5'd7);
    #2;
    checkOutput("bypass_cafe", rdata_a, 32'hCAFEF00D);
    checkOutput("nobypass_old", nb_rdata_a, 32'h12345678);
    applyStimulus(1'b1, 5'd7, 32'hAABBCCDD, 4'b1010, 5'd7, 5'd7);
    #2;
    checkOutput("bypass_partial", rdata_b, 32'hAAFECC0D);
    checkOutput("nobypass_partial", nb_rdata_b, 32'hCAFEF00D);

    // Writes to the zero register and with no strobes are dropped
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111, 5'd0, 5'd7);
    #2;
    checkOutput("zero_reg_bypass", rdata_a, 32'h0);
    applyStimulus(1'b1, 5'd9, 32'h99999999, 4'b0000, 5'd0, 5'd9);
    #2;
    checkOutput("zero_strobe_bypass", rdata_b, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd0, 5'd9);
    #2;
    checkOutput("zero_reg_read", rdata_a, 32'h0);
    checkOutput("zero_strobe_read", rdata_b, 32'h0);
    checkOutput("count_after_drops", {16'h0, wr_count}, 32'd5);

    // Fill regs 1..31 with their own indices
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 4'b1111, 5'(i), 5'(i - 1));
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd3, 5'd31);
    #2;
    checkOutput("fill_read3", rdata_a, 32'd3);
    checkOutput("fill_read31", rdata_b, 32'd31);
    checkOutput("count_after_fill", {16'h0, wr_count}, 32'd36);

    // Mid-cycle reset pulse with a write held on the inputs
    applyStimulus(1'b1, 5'd3, 32'h00000003, 4'b1111, 5'd3, 5'd31);
    rst = 1'b0;
    #1;
    checkOutput("rst_read_a", rdata_a, 32'h0);
    checkOutput("rst_read_b", rdata_b, 32'h0);
    checkOutput("rst_wr_count", {16'h0, wr_count}, 32'h0);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd3, 5'd31);
    #2;
    checkOutput("post_rst_write3", rdata_a, 32'd3);
    checkOutput("post_rst_reg31", rdata_b, 32'h0);
    checkOutput("post_rst_count", {16'h0, wr_count}, 32'd1);

    // Saturation of the write counter
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(1'b1, 5'd1, 32'(i), 4'b1111, 5'd1, 5'd2);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd1, 5'd2);
    #2;
    checkOutput("saturated", {16'h0, wr_count}, 32'h0000FFFF);
    checkOutput("last_sat_data", rdata_a, 32'd65539);
    applyStimulus(1'b1, 5'd2, 32'h0, 4'b1111, 5'd1, 5'd2);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'b0000, 5'd1, 5'd2);
    #2;
    checkOutput("saturated_hold", {16'h0, wr_count}, 32'h0000FFFF);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file
